// File: rtl/bram_dual_mask_clr_pkg.sv
// Shared constants, clear-engine states and helpers for the masked
// dual-port frame/line RAM.
package bram_pkg;

    localparam int RD_OLD = 0;
    localparam int RD_NEW = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_e;

    function automatic int lane_w(input int dw, input int lanes);
        return dw / lanes;
    endfunction

endpackage

// File: rtl/bram_dual_mask_clr_if.sv
// Port bundle for the masked dual-port RAM: two memory ports plus the
// bulk-clear request/status signals.
interface bram_dual_mask_clr_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 48,
    parameter int LANES      = 4
);

    logic                  cena;
    logic                  gwena;
    logic [LANES-1:0]      wena;
    logic [ADDR_WIDTH-1:0] addra;
    logic [DATA_WIDTH-1:0] dina;
    logic [DATA_WIDTH-1:0] douta;
    logic                  valida;

    logic                  cenb;
    logic                  gwenb;
    logic [LANES-1:0]      wenb;
    logic [ADDR_WIDTH-1:0] addrb;
    logic [DATA_WIDTH-1:0] dinb;
    logic [DATA_WIDTH-1:0] doutb;
    logic                  validb;

    logic                  clr_req;
    logic [DATA_WIDTH-1:0] clr_data;
    logic                  clr_busy;
    logic                  clr_done;

    modport master (
        output cena, gwena, wena, addra, dina,
        output cenb, gwenb, wenb, addrb, dinb,
        output clr_req, clr_data,
        input  douta, valida, doutb, validb,
        input  clr_busy, clr_done
    );

    modport slave (
        input  cena, gwena, wena, addra, dina,
        input  cenb, gwenb, wenb, addrb, dinb,
        input  clr_req, clr_data,
        output douta, valida, doutb, validb,
        output clr_busy, clr_done
    );

endinterface

// File: rtl/bram_dual_mask_clr_clear_ctrl.sv
// Bulk-clear engine: walks addresses 0..DEPTH-1 writing a captured fill
// word, one word per cycle, then pulses done.
module bram_clear_ctrl
    import bram_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 640,
    parameter int DATA_WIDTH = 48
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_req_i,
    input  logic [DATA_WIDTH-1:0] clr_data_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    clr_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] fill_q, fill_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        unique case (state_q)
            IDLE: begin
                if (clr_req_i) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    fill_d  = clr_data_i;
                end
            end
            CLEAR: begin
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q == CLEAR);
        done_o = (state_q == DONE);
        we_o   = (state_q == CLEAR);
        addr_o = cnt_q;
        data_o = fill_q;
    end

endmodule

// File: rtl/bram_dual_mask_clr.sv
// True-dual-port lane-masked RAM with cross-port collision merge,
// optional output register and a hardware bulk-clear engine.
module bram_dual_mask_clr
    import bram_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 640,
    parameter int DATA_WIDTH = 48,
    parameter int LANES      = 4,
    parameter int READ_MODE  = 0,
    parameter int OUT_REG    = 0
) (
    input logic                  clk,
    input logic                  rst_n,
    bram_dual_mask_clr_if.slave  bus
);

    localparam int LW = lane_w(DATA_WIDTH, LANES);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  busy;
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic [DATA_WIDTH-1:0] clr_fill;

    bram_clear_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_clr (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_req_i  (bus.clr_req),
        .clr_data_i (bus.clr_data),
        .busy_o     (busy),
        .done_o     (bus.clr_done),
        .we_o       (clr_we),
        .addr_o     (clr_addr),
        .data_o     (clr_fill)
    );

    assign bus.clr_busy = busy;

    logic             a_rd, a_wr, a_in;
    logic             b_rd, b_wr, b_in;
    logic             same;
    logic [LANES-1:0] a_lane, b_lane, b_lane_eff;
    logic [IW-1:0]    a_idx, b_idx;

    always_comb begin
        a_rd  = !bus.cena && !busy && !bus.gwena;
        a_wr  = !bus.cena && !busy &&  bus.gwena;
        b_rd  = !bus.cenb && !busy && !bus.gwenb;
        b_wr  = !bus.cenb && !busy &&  bus.gwenb;
        a_in  = {1'b0, bus.addra} < DEPTH_W;
        b_in  = {1'b0, bus.addrb} < DEPTH_W;
        a_idx = bus.addra[IW-1:0];
        b_idx = bus.addrb[IW-1:0];
        same  = (bus.addra == bus.addrb);
        for (int l = 0; l < LANES; l++) begin
            a_lane[l]     = a_wr && a_in && !bus.wena[l];
            b_lane[l]     = b_wr && b_in && !bus.wenb[l];
            // A owns any lane both ports write at the same address
            b_lane_eff[l] = b_lane[l] && !(same && a_lane[l]);
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr[IW-1:0]] <= clr_fill;
        end
        for (int l = 0; l < LANES; l++) begin
            if (a_lane[l]) begin
                mem[a_idx][l*LW +: LW] <= bus.dina[l*LW +: LW];
            end
            if (b_lane_eff[l]) begin
                mem[b_idx][l*LW +: LW] <= bus.dinb[l*LW +: LW];
            end
        end
    end

    logic [DATA_WIDTH-1:0] a_old, b_old, a_new, b_new;
    logic [DATA_WIDTH-1:0] a_rdata, b_rdata;

    always_comb begin
        a_old = a_in ? mem[a_idx] : '0;
        b_old = b_in ? mem[b_idx] : '0;
        a_new = a_old;
        b_new = b_old;
        for (int l = 0; l < LANES; l++) begin
            if (same && b_lane[l]) a_new[l*LW +: LW] = bus.dinb[l*LW +: LW];
            if (same && a_lane[l]) b_new[l*LW +: LW] = bus.dina[l*LW +: LW];
        end
        a_rdata = (READ_MODE == RD_NEW) ? a_new : a_old;
        b_rdata = (READ_MODE == RD_NEW) ? b_new : b_old;
    end

    logic                  s1_va_q, s1_vb_q;
    logic [DATA_WIDTH-1:0] s1_da_q, s1_da_d;
    logic [DATA_WIDTH-1:0] s1_db_q, s1_db_d;

    always_comb begin
        s1_da_d = a_rd ? a_rdata : s1_da_q;
        s1_db_d = b_rd ? b_rdata : s1_db_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_va_q <= 1'b0;
            s1_vb_q <= 1'b0;
            s1_da_q <= '0;
            s1_db_q <= '0;
        end else begin
            s1_va_q <= a_rd;
            s1_vb_q <= b_rd;
            s1_da_q <= s1_da_d;
            s1_db_q <= s1_db_d;
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic                  va_q, vb_q;
        logic [DATA_WIDTH-1:0] da_q, db_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                va_q <= 1'b0;
                vb_q <= 1'b0;
                da_q <= '0;
                db_q <= '0;
            end else begin
                va_q <= s1_va_q;
                vb_q <= s1_vb_q;
                if (s1_va_q) da_q <= s1_da_q;
                if (s1_vb_q) db_q <= s1_db_q;
            end
        end

        assign bus.douta  = da_q;
        assign bus.doutb  = db_q;
        assign bus.valida = va_q;
        assign bus.validb = vb_q;
    end else begin : g_noreg
        assign bus.douta  = s1_da_q;
        assign bus.doutb  = s1_db_q;
        assign bus.valida = s1_va_q;
        assign bus.validb = s1_vb_q;
    end

endmodule

// File: tb/tb_bram_dual_mask_clr.sv
// Directed bench: one old-data/no-outreg instance and one new-data/outreg
// instance driven with identical stimulus.
`timescale 1ns/1ps
module tb_bram_dual_mask_clr;

    localparam int AW  = 10;
    localparam int DEP = 640;
    localparam int DW  = 48;
    localparam int LN  = 4;

    localparam logic [DW-1:0] F1 = 48'h0F0F0F0F0F0F;
    localparam logic [DW-1:0] F2 = 48'h3C3C3C3C3C3C;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    bram_dual_mask_clr_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANES(LN)) if0 ();
    bram_dual_mask_clr_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANES(LN)) if1 ();

    assign if1.cena     = if0.cena;
    assign if1.gwena    = if0.gwena;
    assign if1.wena     = if0.wena;
    assign if1.addra    = if0.addra;
    assign if1.dina     = if0.dina;
    assign if1.cenb     = if0.cenb;
    assign if1.gwenb    = if0.gwenb;
    assign if1.wenb     = if0.wenb;
    assign if1.addrb    = if0.addrb;
    assign if1.dinb     = if0.dinb;
    assign if1.clr_req  = if0.clr_req;
    assign if1.clr_data = if0.clr_data;

    bram_dual_mask_clr #(
        .ADDR_WIDTH(AW), .DEPTH(DEP), .DATA_WIDTH(DW), .LANES(LN),
        .READ_MODE(0), .OUT_REG(0)
    ) u_old (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.slave)
    );

    bram_dual_mask_clr #(
        .ADDR_WIDTH(AW), .DEPTH(DEP), .DATA_WIDTH(DW), .LANES(LN),
        .READ_MODE(1), .OUT_REG(1)
    ) u_new (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if0.cena  = 1'b1;
        if0.cenb  = 1'b1;
        if0.gwena = 1'b0;
        if0.gwenb = 1'b0;
        if0.wena  = '1;
        if0.wenb  = '1;
    endtask

    task automatic drv_a(input logic gw, input logic [LN-1:0] wen,
                         input logic [AW-1:0] ad, input logic [DW-1:0] d);
        if0.cena  = 1'b0;
        if0.gwena = gw;
        if0.wena  = wen;
        if0.addra = ad;
        if0.dina  = d;
    endtask

    task automatic drv_b(input logic gw, input logic [LN-1:0] wen,
                         input logic [AW-1:0] ad, input logic [DW-1:0] d);
        if0.cenb  = 1'b0;
        if0.gwenb = gw;
        if0.wenb  = wen;
        if0.addrb = ad;
        if0.dinb  = d;
    endtask

    task automatic wr_a(input logic [AW-1:0] ad, input logic [DW-1:0] d,
                        input logic [LN-1:0] wen);
        drv_a(1'b1, wen, ad, d);
        tick();
        idle();
    endtask

    task automatic rd_b(input string tag, input logic [AW-1:0] ad,
                        input logic [DW-1:0] exp);
        drv_b(1'b0, '1, ad, '0);
        tick();
        idle();
        chk({tag, ".d0"}, if0.doutb, exp);
        chk({tag, ".v0"}, if0.validb, 1);
        chk({tag, ".v1early"}, if1.validb, 0);
        tick();
        chk({tag, ".hold0"}, if0.doutb, exp);
        chk({tag, ".v0off"}, if0.validb, 0);
        chk({tag, ".d1"}, if1.doutb, exp);
        chk({tag, ".v1"}, if1.validb, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout at %0t want finish", $time);
        $fatal(1);
    end

    initial begin
        int n_busy0, n_busy1, n_done, done_at, miss;

        idle();
        if0.addra    = '0;
        if0.addrb    = '0;
        if0.dina     = '0;
        if0.dinb     = '0;
        if0.clr_req  = 1'b1;
        if0.clr_data = F1;
        drv_a(1'b0, '1, 10'd1, '0);
        drv_b(1'b1, '0, 10'd2, '1);
        repeat (3) tick();
        chk("rst.douta0", if0.douta, 0);
        chk("rst.doutb0", if0.doutb, 0);
        chk("rst.valida0", if0.valida, 0);
        chk("rst.validb0", if0.validb, 0);
        chk("rst.busy0", if0.clr_busy, 0);
        chk("rst.done0", if0.clr_done, 0);
        chk("rst.douta1", if1.douta, 0);
        chk("rst.valida1", if1.valida, 0);
        chk("rst.busy1", if1.clr_busy, 0);
        if0.clr_req = 1'b0;
        idle();
        rst_n = 1'b1;
        tick();

        wr_a(10'd5, '0, 4'b0000);
        wr_a(10'd5, 48'hAAABBBCCCDDD, 4'b1010);
        rd_b("mask", 10'd5, 48'h000BBB000DDD);

        wr_a(10'd7, '0, 4'b0000);
        drv_a(1'b1, 4'b1100, 10'd7, 48'h111111111111);
        drv_b(1'b1, 4'b0000, 10'd7, 48'h222222222222);
        tick();
        idle();
        rd_b("wcol", 10'd7, 48'h222222111111);

        drv_a(1'b1, 4'b0000, 10'd10, 48'hABCABCABCABC);
        drv_b(1'b1, 4'b0000, 10'd11, 48'h123412341234);
        tick();
        idle();
        rd_b("dual10", 10'd10, 48'hABCABCABCABC);
        rd_b("dual11", 10'd11, 48'h123412341234);

        wr_a(10'd9, 48'h5, 4'b0000);
        drv_a(1'b1, 4'b0000, 10'd9, 48'hF);
        drv_b(1'b0, '1, 10'd9, '0);
        tick();
        idle();
        chk("rwcol.old", if0.doutb, 48'h5);
        tick();
        chk("rwcol.new", if1.doutb, 48'hF);

        drv_a(1'b1, 4'b0111, 10'd9, 48'h123456789ABC);
        drv_b(1'b0, '1, 10'd9, '0);
        tick();
        idle();
        chk("rwpart.old", if0.doutb, 48'hF);
        tick();
        chk("rwpart.new", if1.doutb, 48'h12300000000F);

        drv_b(1'b1, 4'b1110, 10'd9, 48'h000000000777);
        drv_a(1'b0, '1, 10'd9, '0);
        tick();
        idle();
        chk("rwrev.old", if0.douta, 48'h12300000000F);
        chk("rwrev.v0", if0.valida, 1);
        tick();
        chk("rwrev.new", if1.douta, 48'h123000000777);
        chk("rwrev.v1", if1.valida, 1);
        rd_b("rwafter", 10'd9, 48'h123000000777);

        wr_a(10'd639, 48'h639639639639, 4'b0000);
        rd_b("top639", 10'd639, 48'h639639639639);
        wr_a(10'd700, 48'hFFFFFFFFFFFF, 4'b0000);
        rd_b("oor700", 10'd700, '0);
        rd_b("oor640", 10'd640, '0);

        wr_a(10'd3, 48'h333333333333, 4'b0000);
        if0.clr_data = F1;
        if0.clr_req  = 1'b1;
        drv_b(1'b0, '1, 10'd5, '0);
        tick();
        idle();
        if0.clr_req  = 1'b0;
        if0.clr_data = '0;
        chk("clr.busy_on", if0.clr_busy, 1);
        chk("clr.rdpre0", if0.doutb, 48'h000BBB000DDD);
        chk("clr.rdprev0", if0.validb, 1);
        n_busy0 = 0;
        n_busy1 = 0;
        n_done  = 0;
        done_at = -1;
        for (int c = 0; c < 700; c++) begin
            if (if0.clr_busy) n_busy0++;
            if (if1.clr_busy) n_busy1++;
            if (if0.clr_done) begin
                n_done++;
                done_at = c;
            end
            if (c == 1) chk("clr.rdprev1", if1.validb, 1);
            if (c == 10) begin
                drv_a(1'b1, 4'b0000, 10'd3, 48'hFFFFFFFFFFFF);
                drv_b(1'b0, '1, 10'd3, '0);
            end
            if (c == 11) begin
                idle();
                chk("clr.rdign", if0.validb, 0);
            end
            if (c == 20) if0.clr_req = 1'b1;
            if (c == 630) if0.clr_req = 1'b0;
            tick();
        end
        chk("clr.nbusy0", n_busy0, 640);
        chk("clr.nbusy1", n_busy1, 640);
        chk("clr.ndone", n_done, 1);
        chk("clr.doneat", done_at, 640);
        rd_b("clr.a0", 10'd0, F1);
        rd_b("clr.a3", 10'd3, F1);
        rd_b("clr.a639", 10'd639, F1);

        if0.clr_data = F2;
        if0.clr_req  = 1'b1;
        tick();
        if0.clr_req = 1'b0;
        miss = 0;
        for (int c = 0; c < 100; c++) begin
            if (!if0.clr_busy) miss++;
            tick();
        end
        chk("rstclr.busy100", miss, 0);
        rst_n = 1'b0;
        #1;
        chk("rstclr.busy0", if0.clr_busy, 0);
        chk("rstclr.busy1", if1.clr_busy, 0);
        n_done = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (if0.clr_done || if1.clr_done) n_done++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (if0.clr_done || if1.clr_done || if0.clr_busy) n_done++;
        end
        chk("rstclr.nodone", n_done, 0);
        rd_b("rstclr.a99", 10'd99, F2);
        rd_b("rstclr.a100", 10'd100, F1);
        rd_b("rstclr.a0", 10'd0, F2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
